// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_if
// Brief    : Host-byte / fetch-control bundle between the sequencer and its peers.
// Revision : 1.0
// ============================================================================
interface fetch_sequencer_if #(
    parameter int INSTMEM_SIZE = 8,
    parameter int MEM_SIZE     = 8
);
    logic [7:0]              i_rx_data;
    logic                    i_rx_valid;
    logic                    i_halt;
    logic                    o_pc_reset;
    logic                    o_pc_enable;
    logic                    o_instru_mem_enable;
    logic                    o_read_enable;
    logic                    o_write_enable;
    logic [MEM_SIZE-1:0]     o_write_data;
    logic [INSTMEM_SIZE-1:0] o_write_addr;
    logic [2:0]              o_state;
    logic                    o_load_done;
    logic                    o_done;

    modport slave (
        input  i_rx_data, i_rx_valid, i_halt,
        output o_pc_reset, o_pc_enable, o_instru_mem_enable, o_read_enable,
               o_write_enable, o_write_data, o_write_addr, o_state,
               o_load_done, o_done
    );

    modport master (
        output i_rx_data, i_rx_valid, i_halt,
        input  o_pc_reset, o_pc_enable, o_instru_mem_enable, o_read_enable,
               o_write_enable, o_write_data, o_write_addr, o_state,
               o_load_done, o_done
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Host byte-command sequencer: loads instruction memory, then runs
//            the fetch stage continuously or single-stepped until HALT.
// Revision : 1.0
// ============================================================================
module fetch_sequencer #(
    parameter int         INSTMEM_SIZE = 8,
    parameter int         MEM_SIZE     = 8,
    parameter logic [7:0] CMD_LOAD     = 8'h4C,
    parameter logic [7:0] CMD_CONT     = 8'h43,
    parameter logic [7:0] CMD_STEP     = 8'h53,
    parameter logic [7:0] CMD_NEXT     = 8'h4E,
    parameter logic [7:0] CMD_RESET    = 8'h52
) (
    input  wire logic         i_clock,
    input  wire logic         i_reset,
    fetch_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_RUN   = 3'd3,
        S_STEP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] c_HALT_BYTE = 8'hFF;

    state_t                  r_state, w_next;
    logic [INSTMEM_SIZE-1:0] r_addr, w_addr_next, w_addr_inc;
    logic [1:0]              r_ff_cnt, w_ff_cnt_next;
    logic                    r_load_end, w_load_end_next;
    logic                    w_step_pulse, w_we_next;
    logic [MEM_SIZE-1:0]     r_wdata, w_wdata_next;
    logic [INSTMEM_SIZE-1:0] r_waddr, w_waddr_next;
    logic                    r_pc_reset, r_pc_enable, r_mem_en, r_rd_en, r_we;
    logic                    r_load_done, r_done;
    logic                    w_rx_ff;

    assign w_addr_inc = r_addr + 1'b1;
    assign w_rx_ff    = (bus.i_rx_data == c_HALT_BYTE);

    always_comb begin
        w_next          = r_state;
        w_addr_next     = r_addr;
        w_ff_cnt_next   = r_ff_cnt;
        w_load_end_next = r_load_end;
        w_we_next       = 1'b0;
        w_wdata_next    = r_wdata;
        w_waddr_next    = r_waddr;
        w_step_pulse    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_rx_valid && bus.i_rx_data == CMD_LOAD) begin
                    w_next          = S_LOAD;
                    w_addr_next     = '0;
                    w_ff_cnt_next   = 2'd0;
                    w_load_end_next = 1'b0;
                end
            end
            S_LOAD: begin
                // The terminating byte is written while still in LOAD; READY follows one cycle later.
                if (r_load_end) begin
                    w_next          = S_READY;
                    w_load_end_next = 1'b0;
                end else if (bus.i_rx_valid) begin
                    w_we_next     = 1'b1;
                    w_wdata_next  = MEM_SIZE'(bus.i_rx_data);
                    w_waddr_next  = r_addr;
                    w_addr_next   = w_addr_inc;
                    w_ff_cnt_next = w_rx_ff ? ((r_ff_cnt == 2'd3) ? 2'd3 : r_ff_cnt + 2'd1) : 2'd0;
                    if ((w_rx_ff && r_ff_cnt == 2'd3 && w_addr_inc[1:0] == 2'b00) ||
                        (r_addr == '1)) begin
                        w_load_end_next = 1'b1;
                    end
                end
            end
            S_READY: begin
                if (bus.i_rx_valid && bus.i_rx_data == CMD_CONT) begin
                    w_next = S_RUN;
                end else if (bus.i_rx_valid && bus.i_rx_data == CMD_STEP) begin
                    w_next = S_STEP;
                end
            end
            S_RUN: begin
                if (bus.i_halt) begin
                    w_next = S_DONE;
                end
            end
            S_STEP: begin
                if (bus.i_halt) begin
                    w_next = S_DONE;
                end else if (bus.i_rx_valid && bus.i_rx_data == CMD_NEXT) begin
                    w_step_pulse = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.i_rx_valid && bus.i_rx_data == CMD_RESET) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_ff_cnt    <= 2'd0;
            r_load_end  <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_waddr     <= '0;
            r_pc_reset  <= 1'b1;
            r_pc_enable <= 1'b0;
            r_mem_en    <= 1'b0;
            r_rd_en     <= 1'b0;
            r_load_done <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_addr      <= w_addr_next;
            r_ff_cnt    <= w_ff_cnt_next;
            r_load_end  <= w_load_end_next;
            r_we        <= w_we_next;
            r_wdata     <= w_wdata_next;
            r_waddr     <= w_waddr_next;
            // Control outputs follow the state being entered so they change on the entry edge.
            r_pc_reset  <= (w_next == S_IDLE) || (w_next == S_LOAD) || (w_next == S_READY);
            r_pc_enable <= (w_next == S_RUN) || w_step_pulse;
            r_mem_en    <= (w_next != S_IDLE);
            r_rd_en     <= (w_next == S_READY) || (w_next == S_RUN) ||
                           (w_next == S_STEP)  || (w_next == S_DONE);
            r_load_done <= (w_next == S_READY) || (w_next == S_RUN) ||
                           (w_next == S_STEP)  || (w_next == S_DONE);
            r_done      <= (w_next == S_DONE);
        end
    end

    assign bus.o_state             = r_state;
    assign bus.o_pc_reset          = r_pc_reset;
    assign bus.o_pc_enable         = r_pc_enable;
    assign bus.o_instru_mem_enable = r_mem_en;
    assign bus.o_read_enable       = r_rd_en;
    assign bus.o_write_enable      = r_we;
    assign bus.o_write_data        = r_wdata;
    assign bus.o_write_addr        = r_waddr;
    assign bus.o_load_done         = r_load_done;
    assign bus.o_done              = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Randomized scoreboard bench for fetch_sequencer.
// Revision : 1.0
// ============================================================================
module tb_fetch_sequencer;

    logic clk;
    logic rst;

    fetch_sequencer_if #(.INSTMEM_SIZE(8), .MEM_SIZE(8)) bus ();

    fetch_sequencer dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    bit         pe_q[$];
    logic [7:0] hist[$];
    bit         loading;
    int         total;
    int         bad;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write and every step-mode enable pulse must be expected.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_write_enable) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("write_addr", int'(bus.o_write_addr), int'(e.addr));
                    chk("write_data", int'(bus.o_write_data), int'(e.data));
                end
                chk("write_state_is_load", int'(bus.o_state), 1);
                chk("write_and_pc_enable", int'(bus.o_pc_enable), 0);
            end
            if (bus.o_pc_enable && bus.o_state == 3'd4) begin
                if (pe_q.size() == 0) chk("unexpected_step_pulse", 1, 0);
                else void'(pe_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        tick(1);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic start_load();
        send(8'h4C);
        hist.delete();
        loading = 1'b1;
    endtask

    // Reference: byte i of a load lands at address i; the load closes on a complete
    // FF FF FF FF word or on the 256th byte.
    task automatic send_load_byte(input logic [7:0] b);
        if (loading) begin
            int idx;
            hist.push_back(b);
            idx = hist.size() - 1;
            exp_wr.push_back('{addr: idx[7:0], data: b});
            if (idx == 255) loading = 1'b0;
            else if (idx % 4 == 3 && hist[idx] == 8'hFF && hist[idx-1] == 8'hFF &&
                     hist[idx-2] == 8'hFF && hist[idx-3] == 8'hFF) loading = 1'b0;
        end
        send(b);
    endtask

    task automatic halt_and_reset();
        bus.i_halt = 1'b1;
        tick(1);
        bus.i_halt = 1'b0;
        chk("halt_to_done", int'(bus.o_state), 5);
        chk("done_flag", int'(bus.o_done), 1);
        chk("done_pc_enable", int'(bus.o_pc_enable), 0);
        send(8'h52);
        chk("reset_cmd_state", int'(bus.o_state), 0);
        chk("reset_cmd_load_done", int'(bus.o_load_done), 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        loading = 1'b0;
        rst = 1'b1;
        bus.i_rx_data = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_halt = 1'b0;
        tick(3);

        chk("rst_state", int'(bus.o_state), 0);
        chk("rst_pc_reset", int'(bus.o_pc_reset), 1);
        chk("rst_pc_enable", int'(bus.o_pc_enable), 0);
        chk("rst_write_enable", int'(bus.o_write_enable), 0);
        chk("rst_mem_enable", int'(bus.o_instru_mem_enable), 0);
        chk("rst_read_enable", int'(bus.o_read_enable), 0);
        chk("rst_load_done", int'(bus.o_load_done), 0);
        chk("rst_done", int'(bus.o_done), 0);
        rst = 1'b0;
        tick(1);

        // Plain load stays in LOAD, then an aligned HALT word finishes it.
        start_load();
        send_load_byte(8'h11);
        send_load_byte(8'h22);
        send_load_byte(8'h33);
        send_load_byte(8'h44);
        tick(1);
        chk("load_state", int'(bus.o_state), 1);
        chk("load_pc_reset", int'(bus.o_pc_reset), 1);
        chk("load_mem_enable", int'(bus.o_instru_mem_enable), 1);
        for (int i = 0; i < 4; i++) send_load_byte(8'hFF);
        tick(2);
        chk("ready_state", int'(bus.o_state), 2);
        chk("ready_load_done", int'(bus.o_load_done), 1);
        chk("ready_read_enable", int'(bus.o_read_enable), 1);
        chk("ready_pc_reset", int'(bus.o_pc_reset), 1);

        // Continuous run, halt after ten cycles.
        send(8'h43);
        chk("run_state", int'(bus.o_state), 3);
        chk("run_pc_reset", int'(bus.o_pc_reset), 0);
        for (int i = 0; i < 9; i++) begin
            chk("run_pc_enable", int'(bus.o_pc_enable), 1);
            tick(1);
        end
        halt_and_reset();

        // Six FFs: only the aligned first word closes the load.
        start_load();
        for (int i = 0; i < 6; i++) send_load_byte(8'hFF);
        send_load_byte(8'h11);
        send_load_byte(8'h22);
        tick(2);
        chk("ff6_state", int'(bus.o_state), 2);

        // Step mode: each NEXT gives one pulse; NEXT together with halt gives none.
        send(8'h53);
        chk("step_state", int'(bus.o_state), 4);
        chk("step_pc_reset", int'(bus.o_pc_reset), 0);
        chk("step_pc_enable", int'(bus.o_pc_enable), 0);
        for (int i = 0; i < 2 + int'($urandom_range(0, 4)); i++) begin
            pe_q.push_back(1'b1);
            send(8'h4E);
            tick($urandom_range(0, 3));
        end
        bus.i_rx_data = 8'h4E;
        bus.i_rx_valid = 1'b1;
        bus.i_halt = 1'b1;
        tick(1);
        bus.i_rx_valid = 1'b0;
        bus.i_halt = 1'b0;
        chk("step_halt_state", int'(bus.o_state), 5);
        chk("step_halt_pc_enable", int'(bus.o_pc_enable), 0);
        send(8'h52);
        chk("step_reset_state", int'(bus.o_state), 0);

        // Random programs with scattered unaligned FF runs and random gaps.
        for (int r = 0; r < 4; r++) begin
            int len;
            start_load();
            len = $urandom_range(0, 30);
            for (int i = 0; i < len; i++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                if (b == 8'h43 || b == 8'h53) b = 8'hFF;
                send_load_byte(b);
                tick($urandom_range(0, 2));
            end
            while (loading && hist.size() % 4 != 0) send_load_byte(8'h00);
            for (int i = 0; i < 4; i++) send_load_byte(8'hFF);
            tick(3);
            chk("rand_ready_state", int'(bus.o_state), 2);
            chk("rand_load_done", int'(bus.o_load_done), 1);
            send(8'h43);
            tick($urandom_range(1, 5));
            halt_and_reset();
        end

        // 256 non-FF bytes wrap the address counter and end the load.
        start_load();
        for (int i = 0; i < 256; i++) send_load_byte(8'($urandom_range(0, 254)));
        tick(2);
        chk("wrap_state", int'(bus.o_state), 2);
        chk("wrap_load_done", int'(bus.o_load_done), 1);
        send(8'h43);
        halt_and_reset();

        // Reset mid-load at address 7: no write, back to IDLE at address 0.
        start_load();
        for (int i = 0; i < 7; i++) send_load_byte(8'h10 + 8'(i));
        bus.i_rx_data = 8'h77;
        bus.i_rx_valid = 1'b1;
        rst = 1'b1;
        tick(1);
        bus.i_rx_valid = 1'b0;
        rst = 1'b0;
        loading = 1'b0;
        chk("abort_state", int'(bus.o_state), 0);
        chk("abort_write_enable", int'(bus.o_write_enable), 0);
        chk("abort_pc_reset", int'(bus.o_pc_reset), 1);
        start_load();
        send_load_byte(8'hAA);
        tick(2);

        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_pulses", pe_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
